// File: rtl/noc_output_port_scheduler.sv
// Output-port scheduler for the NoC router: round-robin arbitration over the input ports,
// wormhole lock from head to tail, and a downstream credit counter that gates switch transfers.
module noc_output_port_scheduler #(
  parameter int PORTS   = 5,
  parameter int CREDITS = 8,
  parameter int CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic             noc_clk,
  input  logic             noc_rst_n,
  input  logic [PORTS-1:0] req_i,
  input  logic [PORTS-1:0] tail_i,
  input  logic             fire_i,
  input  logic             credit_ret_i,
  output logic [PORTS-1:0] grant_o,
  output logic             send_en_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] credit_cnt_o,
  output logic [1:0]       err_o
);

  localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [CNT_W-1:0] MAX_CREDITS = CNT_W'(CREDITS);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(PORTS - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             release_pkt;
  int               cand;

  // First requester at or after rr_ptr, wrapping around the port list.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 0; k < PORTS; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= PORTS) cand = cand - PORTS;
      if (!pick_valid && req_i[IDX_W'(cand)]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  assign release_pkt = (state == LOCKED) && fire_i && tail_i[owner];

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state   <= IDLE;
      grant_o <= '0;
      owner   <= '0;
      rr_ptr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state   <= LOCKED;
            owner   <= pick_idx;
            grant_o <= PORTS'(1) << pick_idx;
          end
        end
        LOCKED: begin
          // Lock is held through bubbles; only the owner's tail transfer frees the port.
          if (release_pkt) begin
            state   <= IDLE;
            grant_o <= '0;
            rr_ptr  <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o    = (state == LOCKED);
  assign send_en_o = busy_o && (credit_cnt_o != '0);

  // Credits track downstream slots regardless of FSM state; misuse sets sticky flags.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      credit_cnt_o <= MAX_CREDITS;
      err_o        <= 2'b00;
    end else begin
      case ({fire_i, credit_ret_i})
        2'b10: begin
          if (credit_cnt_o == '0) err_o[0] <= 1'b1;
          else                    credit_cnt_o <= credit_cnt_o - 1'b1;
        end
        2'b01: begin
          if (credit_cnt_o == MAX_CREDITS) err_o[1] <= 1'b1;
          else                             credit_cnt_o <= credit_cnt_o + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_output_port_scheduler.sv
// Scoreboard bench for noc_output_port_scheduler: a packet-level reference model predicts
// each cycle's outputs and every grant; a free-running monitor compares what the DUT presents.
module tb_noc_output_port_scheduler;

  localparam int PORTS   = 5;
  localparam int CREDITS = 8;
  localparam int CNT_W   = $clog2(CREDITS + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [PORTS-1:0] req_i = '0;
  logic [PORTS-1:0] tail_i = '0;
  logic             fire_i = 1'b0;
  logic             credit_ret_i = 1'b0;
  logic [PORTS-1:0] grant_o;
  logic             send_en_o;
  logic             busy_o;
  logic [CNT_W-1:0] credit_cnt_o;
  logic [1:0]       err_o;

  noc_output_port_scheduler #(.PORTS(PORTS), .CREDITS(CREDITS)) dut (
    .noc_clk      (clk),
    .noc_rst_n    (rst_n),
    .req_i        (req_i),
    .tail_i       (tail_i),
    .fire_i       (fire_i),
    .credit_ret_i (credit_ret_i),
    .grant_o      (grant_o),
    .send_en_o    (send_en_o),
    .busy_o       (busy_o),
    .credit_cnt_o (credit_cnt_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PORTS-1:0] grant;
    logic             busy;
    logic             send_en;
    int               credits;
    logic [1:0]       err;
  } status_t;

  status_t status_q[$];
  int      grant_q[$];
  int      errors = 0;
  int      checks = 0;

  // Reference model: which port owns the output, where the search resumes, credits, flags.
  bit       m_locked = 1'b0;
  int       m_owner = 0;
  int       m_ptr = 0;
  int       m_credits = CREDITS;
  bit [1:0] m_err = 2'b00;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit model_send();
    return m_locked && (m_credits != 0);
  endfunction

  task automatic model_reset();
    m_locked  = 1'b0;
    m_owner   = 0;
    m_ptr     = 0;
    m_credits = CREDITS;
    m_err     = 2'b00;
  endtask

  // Drive one cycle of inputs and predict the state the next clock edge produces.
  task automatic apply_stimulus(input logic [PORTS-1:0] req, input logic [PORTS-1:0] tail,
                                input logic fire, input logic ret);
    status_t s;
    bit      found;
    @(negedge clk);
    req_i        = req;
    tail_i       = tail;
    fire_i       = fire;
    credit_ret_i = ret;

    if (fire && !ret) begin
      if (m_credits == 0) m_err[0] = 1'b1;
      else                m_credits--;
    end else if (ret && !fire) begin
      if (m_credits == CREDITS) m_err[1] = 1'b1;
      else                      m_credits++;
    end

    if (!m_locked) begin
      found = 1'b0;
      for (int k = 0; k < PORTS; k++) begin
        if (!found && req[(m_ptr + k) % PORTS]) begin
          found    = 1'b1;
          m_owner  = (m_ptr + k) % PORTS;
          m_locked = 1'b1;
          grant_q.push_back(m_owner);
        end
      end
    end else if (fire && tail[m_owner]) begin
      m_locked = 1'b0;
      m_ptr    = (m_owner + 1) % PORTS;
    end

    s.grant   = m_locked ? PORTS'(1 << m_owner) : '0;
    s.busy    = m_locked;
    s.send_en = model_send();
    s.credits = m_credits;
    s.err     = m_err;
    status_q.push_back(s);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_grant"},   32'(grant_o),      32'd0);
    check_output({tag, "_busy"},    32'(busy_o),       32'd0);
    check_output({tag, "_send_en"}, 32'(send_en_o),    32'd0);
    check_output({tag, "_credits"}, 32'(credit_cnt_o), 32'(CREDITS));
    check_output({tag, "_err"},     32'(err_o),        32'd0);
  endtask

  // Monitor: one predicted status per clock edge, plus one predicted winner per new grant.
  logic [PORTS-1:0] prev_grant = '0;
  status_t          exp_s;
  int               exp_port;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (status_q.size() > 0) begin
        exp_s = status_q.pop_front();
        check_output("grant",   32'(grant_o),      32'(exp_s.grant));
        check_output("busy",    32'(busy_o),       32'(exp_s.busy));
        check_output("send_en", 32'(send_en_o),    32'(exp_s.send_en));
        check_output("credits", 32'(credit_cnt_o), 32'(exp_s.credits));
        check_output("err",     32'(err_o),        32'(exp_s.err));
      end
      if (grant_o != '0 && prev_grant == '0) begin
        if (grant_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL grant_unexpected: got %0h, expected no new grant at %0t", grant_o, $time);
        end else begin
          exp_port = grant_q.pop_front();
          check_output("grant_winner", 32'(grant_o), 32'(1 << exp_port));
        end
      end
      prev_grant = grant_o;
    end
  end

  initial begin
    int sent;
    int packets;
    logic [PORTS-1:0] tail;
    logic fire;
    logic ret;

    // Power-on reset
    #12;
    check_reset_values("por");
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Single-flit packet on port 2
    apply_stimulus(5'b00100, 5'b00100, 1'b0, 1'b0);
    apply_stimulus(5'b00100, 5'b00100, model_send(), 1'b0);
    apply_stimulus(5'b00000, 5'b00000, 1'b0, 1'b0);

    // Everyone requesting, 3-flit packets, credit returned alongside each transfer
    sent = 0;
    packets = 0;
    for (int cyc = 0; cyc < 200 && packets < 6; cyc++) begin
      fire = model_send();
      tail = (fire && sent == 2) ? PORTS'(1 << m_owner) : '0;
      apply_stimulus(5'b11111, tail, fire, fire);
      if (fire) begin
        sent++;
        if (sent == 3) begin
          sent = 0;
          packets++;
        end
      end
    end
    apply_stimulus(5'b00000, 5'b00000, 1'b0, 1'b0);

    // Credit exhaustion, forced fire at zero, recovery, simultaneous fire/return, overflow
    apply_stimulus(5'b00000, 5'b00000, 1'b0, 1'b1);
    apply_stimulus(5'b00001, 5'b00000, 1'b0, 1'b0);
    for (int i = 0; i < 10 && m_credits > 0; i++)
      apply_stimulus(5'b00001, 5'b00000, 1'b1, 1'b0);
    apply_stimulus(5'b00001, 5'b00000, 1'b1, 1'b0);
    apply_stimulus(5'b00001, 5'b00000, 1'b0, 1'b1);
    apply_stimulus(5'b00001, 5'b00001, 1'b1, 1'b0);
    repeat (5) apply_stimulus(5'b00000, 5'b00000, 1'b0, 1'b1);
    apply_stimulus(5'b00000, 5'b00000, 1'b1, 1'b1);
    repeat (3) apply_stimulus(5'b00000, 5'b00000, 1'b0, 1'b1);
    apply_stimulus(5'b00000, 5'b00000, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a packet with 3 credits left
    apply_stimulus(5'b10000, 5'b00000, 1'b0, 1'b0);
    repeat (5) apply_stimulus(5'b10000, 5'b00000, 1'b1, 1'b0);
    @(negedge clk);
    req_i = '0; tail_i = '0; fire_i = 1'b0; credit_ret_i = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    apply_stimulus(5'b11111, 5'b00001, 1'b0, 1'b0);
    apply_stimulus(5'b11111, 5'b00001, model_send(), 1'b0);
    apply_stimulus(5'b00000, 5'b00000, 1'b0, 1'b0);

    // Wormhole bubble on port 1 while port 3 waits
    apply_stimulus(5'b00010, 5'b00000, 1'b0, 1'b0);
    apply_stimulus(5'b01010, 5'b00000, 1'b1, 1'b1);
    repeat (4) apply_stimulus(5'b01000, 5'b01000, 1'b0, 1'b0);
    apply_stimulus(5'b01010, 5'b00010, 1'b1, 1'b1);
    apply_stimulus(5'b01000, 5'b00000, 1'b0, 1'b0);
    apply_stimulus(5'b01000, 5'b01000, 1'b1, 1'b1);
    apply_stimulus(5'b00000, 5'b00000, 1'b0, 1'b0);

    // Randomized traffic, with occasional protocol violations
    for (int cyc = 0; cyc < 400; cyc++) begin
      fire = model_send() ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
      ret  = (m_credits < CREDITS) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 29) == 0);
      apply_stimulus(PORTS'($urandom_range(0, 31)), PORTS'($urandom_range(0, 31)), fire, ret);
    end
    apply_stimulus(5'b00000, 5'b00000, 1'b0, 1'b0);
    apply_stimulus(5'b00000, 5'b00000, 1'b0, 1'b0);

    @(posedge clk);
    #3;
    check_output("status_drain", 32'(status_q.size()), 32'd0);
    check_output("grant_drain",  32'(grant_q.size()),  32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
